vu_vxu_utcmd_arbiter: RTL and testbench
=======================================

# vu_vxu_utcmd_arbiter

Arbitrates the VMU unit-stride command/immediate queue pair between the two VXU issue sources: TVEC (vector-thread-vector commands) and VT (vector-thread fetched instructions). A command from a requester may carry a fixed number of following immediate beats; the arbiter locks onto that requester until every announced immediate has been forwarded, so command and immediate streams stay paired. Both output queues are driven from one-entry registered slots. This replaces the combinational TVEC-over-VT mux in front of `vmu_utcmdq` and `vmu_utimmq` with a sequenced, starvation-free scheduler.

## Interface
- `CMD_W`, 19: command beat width (`DEF_VMU_UTCMDQ`).
- `IMM_W`, 64: immediate beat width (`DEF_VMU_UTIMMQ`).
- `NIMM_W`, 2: width of the per-command immediate count.
- `STARVE_MAX`, 3: consecutive TVEC wins over a waiting VT before VT is forced.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `tvec_cmd_bits` in CMD_W; `tvec_cmd_nimm` in NIMM_W; `tvec_cmd_val` in 1; `tvec_cmd_rdy` out 1: requester 0 command.
- `tvec_imm_bits` in IMM_W; `tvec_imm_val` in 1; `tvec_imm_rdy` out 1: requester 0 immediates.
- `vt_cmd_bits` in CMD_W; `vt_cmd_nimm` in NIMM_W; `vt_cmd_val` in 1; `vt_cmd_rdy` out 1: requester 1 command.
- `vt_imm_bits` in IMM_W; `vt_imm_val` in 1; `vt_imm_rdy` out 1: requester 1 immediates.
- `vmu_utcmdq_bits` out CMD_W; `vmu_utcmdq_val` out 1; `vmu_utcmdq_rdy` in 1.
- `vmu_utimmq_bits` out IMM_W; `vmu_utimmq_val` out 1; `vmu_utimmq_rdy` in 1.
- `busy` out 1: high in IMM state or while either output slot is full.

## Operation
- States: IDLE, IMM. Registers: `owner` (1 b), `rem` (NIMM_W), `starve` (2 b), cmd slot, imm slot.
- Cmd slot can load when empty or draining (`!vmu_utcmdq_val | vmu_utcmdq_rdy`); same rule for imm slot.
- IDLE: if cmd slot can load, grant one valid requester; `*_cmd_rdy` high only for the grantee. Transfer loads slot, `owner`←grantee, `rem`←nimm; next state IMM if nimm≠0, else IDLE.
- Grant rule: TVEC wins when both valid unless `starve == STARVE_MAX`, then VT wins. `starve` increments on a TVEC grant while `vt_cmd_val`; clears on VT grant or whenever `vt_cmd_val` low.
- IMM: no cmd grants (`*_cmd_rdy` both low). `owner`'s `*_imm_rdy` = imm slot can load; non-owner `*_imm_rdy` low. Each transfer loads imm slot, `rem`←`rem`−1; on the transfer with `rem==1` go to IDLE.
- Immediates are never accepted in IDLE. Immediates may be forwarded while the cmd slot is still full.
- Payloads pass unmodified; nimm is not forwarded.

## Timing
- Reset (async assert): state IDLE, `rem`=0, `starve`=0, both slots empty; all `*_val`, `*_rdy`, `busy` low; bits outputs 0. Deassertion sampled synchronously.
- Latency: cmd/imm accepted at edge N is valid on output from cycle N+1.
- Throughput: nimm=0 commands at one per cycle with `vmu_utcmdq_rdy` held high; nimm=k command occupies k+1 cycles minimum; first cycle after IMM→IDLE can grant.
- Slot full and downstream ready same cycle: drain and reload in that cycle, no bubble.
- Downstream stalled: slot holds bits and val stable until rdy.
- Reset mid-IMM: lock, partial immediate stream and slot contents discarded.

## Structure
- Shared package: `CMD_W`, `IMM_W`, `NIMM_W` defaults, state encoding (IDLE=0, IMM=1), requester IDs (TVEC=0, VT=1).
- Sub-module `vu_vxu_utq_slot`: parameterised one-entry valid/ready register, instantiated for cmd and imm.

## Test plan
- TVEC cmd 0x00123 nimm=0, rdy high -> `vmu_utcmdq_bits`=0x00123 one cycle later; no imm beats.
- VT cmd nimm=2, imms 0xA, 0xB -> cmd then imm 0xA, 0xB in order; both `*_cmd_rdy` low for 2 cycles; TVEC cmd waiting meanwhile granted after.
- Both cmd valid every cycle, nimm=0 -> grant order T,T,T,V,T,T,T,V.
- `vmu_utcmdq_rdy` low 5 cycles with slot full -> bits stable, both `*_cmd_rdy` low; rdy high -> drain and reload same cycle.
- TVEC asserts `tvec_imm_val` in IDLE and during VT lock -> `tvec_imm_rdy` stays low, nothing forwarded.
- Reset asserted in IMM with `rem`=1 -> all outputs low immediately; after release new TVEC nimm=0 cmd forwarded normally.

Source files
------------

// File: rtl/vu_vxu_utcmd_arbiter_pkg.sv
// Shared widths, state encoding and requester IDs for the VMU unit-stride
// command/immediate arbiter.
package vu_vxu_utcmd_arbiter_pkg;

  localparam int DEF_CMD_W  = 19;
  localparam int DEF_IMM_W  = 64;
  localparam int DEF_NIMM_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    IMM  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_TVEC = 1'b0,
    REQ_VT   = 1'b1
  } req_e;

endpackage

// File: rtl/vu_vxu_utq_slot.sv
// One-entry registered valid/ready slot; accepts a new beat whenever it is
// empty or being drained in the same cycle.
module vu_vxu_utq_slot
  import vu_vxu_utcmd_arbiter_pkg::*;
#(
  parameter int W = DEF_CMD_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_bits,
  input  logic         in_val,
  output logic         in_rdy,
  output logic [W-1:0] out_bits,
  output logic         out_val,
  input  logic         out_rdy
);

  assign in_rdy = !out_val || out_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_val  <= 1'b0;
      out_bits <= '0;
    end else if (in_rdy) begin
      out_val <= in_val;
      if (in_val) begin
        out_bits <= in_bits;
      end
    end
  end

endmodule

// File: rtl/vu_vxu_utcmd_arbiter.sv
// Arbitrates TVEC and VT command/immediate streams onto the VMU utcmdq/utimmq,
// locking onto a requester until all of its announced immediates are forwarded.
module vu_vxu_utcmd_arbiter
  import vu_vxu_utcmd_arbiter_pkg::*;
#(
  parameter int CMD_W      = DEF_CMD_W,
  parameter int IMM_W      = DEF_IMM_W,
  parameter int NIMM_W     = DEF_NIMM_W,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  tvec_cmd_bits,
  input  logic [NIMM_W-1:0] tvec_cmd_nimm,
  input  logic              tvec_cmd_val,
  output logic              tvec_cmd_rdy,
  input  logic [IMM_W-1:0]  tvec_imm_bits,
  input  logic              tvec_imm_val,
  output logic              tvec_imm_rdy,
  input  logic [CMD_W-1:0]  vt_cmd_bits,
  input  logic [NIMM_W-1:0] vt_cmd_nimm,
  input  logic              vt_cmd_val,
  output logic              vt_cmd_rdy,
  input  logic [IMM_W-1:0]  vt_imm_bits,
  input  logic              vt_imm_val,
  output logic              vt_imm_rdy,
  output logic [CMD_W-1:0]  vmu_utcmdq_bits,
  output logic              vmu_utcmdq_val,
  input  logic              vmu_utcmdq_rdy,
  output logic [IMM_W-1:0]  vmu_utimmq_bits,
  output logic              vmu_utimmq_val,
  input  logic              vmu_utimmq_rdy,
  output logic              busy
);

  state_e            state;
  state_e            state_nxt;
  req_e              owner;
  logic [NIMM_W-1:0] rem;
  logic [1:0]        starve;

  logic              cmd_can_load;
  logic              imm_can_load;
  logic              grant_vt;
  logic              cmd_fire;
  logic              imm_fire;
  logic              owner_imm_val;
  logic [CMD_W-1:0]  cmd_in_bits;
  logic [IMM_W-1:0]  imm_in_bits;
  logic [NIMM_W-1:0] grant_nimm;

  // VT only wins a contested grant once TVEC has beaten it STARVE_MAX times in a row.
  always_comb begin
    grant_vt      = vt_cmd_val && (!tvec_cmd_val || (int'(starve) == STARVE_MAX));
    cmd_fire      = (state == IDLE) && cmd_can_load && (tvec_cmd_val || vt_cmd_val);
    owner_imm_val = (owner == REQ_VT) ? vt_imm_val : tvec_imm_val;
    imm_fire      = (state == IMM) && imm_can_load && owner_imm_val;
    cmd_in_bits   = grant_vt ? vt_cmd_bits : tvec_cmd_bits;
    grant_nimm    = grant_vt ? vt_cmd_nimm : tvec_cmd_nimm;
    imm_in_bits   = (owner == REQ_VT) ? vt_imm_bits : tvec_imm_bits;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_fire && (grant_nimm != '0)) state_nxt = IMM;
      IMM:  if (imm_fire && (rem == NIMM_W'(1))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ready outputs are gated by reset so they drop the instant reset asserts.
  always_comb begin
    tvec_cmd_rdy = 1'b0;
    vt_cmd_rdy   = 1'b0;
    tvec_imm_rdy = 1'b0;
    vt_imm_rdy   = 1'b0;
    if (reset) begin
      case (state)
        IDLE: begin
          tvec_cmd_rdy = cmd_can_load && tvec_cmd_val && !grant_vt;
          vt_cmd_rdy   = cmd_can_load && grant_vt;
        end
        IMM: begin
          tvec_imm_rdy = imm_can_load && (owner == REQ_TVEC);
          vt_imm_rdy   = imm_can_load && (owner == REQ_VT);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner  <= REQ_TVEC;
      rem    <= '0;
      starve <= '0;
    end else begin
      if (cmd_fire) begin
        owner <= grant_vt ? REQ_VT : REQ_TVEC;
        rem   <= grant_nimm;
      end else if (imm_fire) begin
        rem <= rem - NIMM_W'(1);
      end
      if (!vt_cmd_val || (cmd_fire && grant_vt)) begin
        starve <= '0;
      end else if (cmd_fire && (starve != 2'd3)) begin
        starve <= starve + 2'd1;
      end
    end
  end

  assign busy = (state == IMM) || vmu_utcmdq_val || vmu_utimmq_val;

  vu_vxu_utq_slot #(.W(CMD_W)) u_cmd_slot (
    .clk      (clk),
    .reset    (reset),
    .in_bits  (cmd_in_bits),
    .in_val   (cmd_fire),
    .in_rdy   (cmd_can_load),
    .out_bits (vmu_utcmdq_bits),
    .out_val  (vmu_utcmdq_val),
    .out_rdy  (vmu_utcmdq_rdy)
  );

  vu_vxu_utq_slot #(.W(IMM_W)) u_imm_slot (
    .clk      (clk),
    .reset    (reset),
    .in_bits  (imm_in_bits),
    .in_val   (imm_fire),
    .in_rdy   (imm_can_load),
    .out_bits (vmu_utimmq_bits),
    .out_val  (vmu_utimmq_val),
    .out_rdy  (vmu_utimmq_rdy)
  );

endmodule

// File: tb/tb_vu_vxu_utcmd_arbiter.sv
// Directed scoreboard bench for vu_vxu_utcmd_arbiter: expected output beats are
// queued as stimulus is driven and popped as the DUT hands them downstream.
module tb_vu_vxu_utcmd_arbiter;
  import vu_vxu_utcmd_arbiter_pkg::*;

  localparam int CMD_W  = DEF_CMD_W;
  localparam int IMM_W  = DEF_IMM_W;
  localparam int NIMM_W = DEF_NIMM_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [CMD_W-1:0]  tvec_cmd_bits;
  logic [NIMM_W-1:0] tvec_cmd_nimm;
  logic              tvec_cmd_val;
  logic              tvec_cmd_rdy;
  logic [IMM_W-1:0]  tvec_imm_bits;
  logic              tvec_imm_val;
  logic              tvec_imm_rdy;
  logic [CMD_W-1:0]  vt_cmd_bits;
  logic [NIMM_W-1:0] vt_cmd_nimm;
  logic              vt_cmd_val;
  logic              vt_cmd_rdy;
  logic [IMM_W-1:0]  vt_imm_bits;
  logic              vt_imm_val;
  logic              vt_imm_rdy;
  logic [CMD_W-1:0]  vmu_utcmdq_bits;
  logic              vmu_utcmdq_val;
  logic              vmu_utcmdq_rdy;
  logic [IMM_W-1:0]  vmu_utimmq_bits;
  logic              vmu_utimmq_val;
  logic              vmu_utimmq_rdy;
  logic              busy;

  int checks = 0;
  int errors = 0;
  logic [CMD_W-1:0] exp_cmd_q[$];
  logic [IMM_W-1:0] exp_imm_q[$];
  logic [7:0] vt_turn = 8'b1000_1000;

  always #5 clk = ~clk;

  vu_vxu_utcmd_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .tvec_cmd_bits   (tvec_cmd_bits),
    .tvec_cmd_nimm   (tvec_cmd_nimm),
    .tvec_cmd_val    (tvec_cmd_val),
    .tvec_cmd_rdy    (tvec_cmd_rdy),
    .tvec_imm_bits   (tvec_imm_bits),
    .tvec_imm_val    (tvec_imm_val),
    .tvec_imm_rdy    (tvec_imm_rdy),
    .vt_cmd_bits     (vt_cmd_bits),
    .vt_cmd_nimm     (vt_cmd_nimm),
    .vt_cmd_val      (vt_cmd_val),
    .vt_cmd_rdy      (vt_cmd_rdy),
    .vt_imm_bits     (vt_imm_bits),
    .vt_imm_val      (vt_imm_val),
    .vt_imm_rdy      (vt_imm_rdy),
    .vmu_utcmdq_bits (vmu_utcmdq_bits),
    .vmu_utcmdq_val  (vmu_utcmdq_val),
    .vmu_utcmdq_rdy  (vmu_utcmdq_rdy),
    .vmu_utimmq_bits (vmu_utimmq_bits),
    .vmu_utimmq_val  (vmu_utimmq_val),
    .vmu_utimmq_rdy  (vmu_utimmq_rdy),
    .busy            (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic t_val, input logic [CMD_W-1:0] t_bits,
                               input logic [NIMM_W-1:0] t_nimm, input logic v_val,
                               input logic [CMD_W-1:0] v_bits, input logic [NIMM_W-1:0] v_nimm);
    tvec_cmd_val  = t_val;
    tvec_cmd_bits = t_bits;
    tvec_cmd_nimm = t_nimm;
    vt_cmd_val    = v_val;
    vt_cmd_bits   = v_bits;
    vt_cmd_nimm   = v_nimm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream handshakes are sampled mid-cycle, ahead of the edge that completes them.
  always @(negedge clk) begin
    if (reset === 1'b1 && vmu_utcmdq_val && vmu_utcmdq_rdy) begin
      if (exp_cmd_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL cmd_unexpected: observed=0x%0h expected=none", vmu_utcmdq_bits);
      end else begin
        checkOutput("cmd_order", 64'(vmu_utcmdq_bits), 64'(exp_cmd_q.pop_front()));
      end
    end
    if (reset === 1'b1 && vmu_utimmq_val && vmu_utimmq_rdy) begin
      if (exp_imm_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL imm_unexpected: observed=0x%0h expected=none", vmu_utimmq_bits);
      end else begin
        checkOutput("imm_order", vmu_utimmq_bits, exp_imm_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0;
    applyStimulus(1'b1, 19'h00AAA, 2'd0, 1'b0, '0, '0);
    tvec_imm_val   = 1'b1;
    tvec_imm_bits  = '0;
    vt_imm_val     = 1'b0;
    vt_imm_bits    = '0;
    vmu_utcmdq_rdy = 1'b1;
    vmu_utimmq_rdy = 1'b1;
    #2;
    $display("[TB] reset state");
    checkOutput("rst_cmd_val", 64'(vmu_utcmdq_val), 64'd0);
    checkOutput("rst_imm_val", 64'(vmu_utimmq_val), 64'd0);
    checkOutput("rst_cmd_bits", 64'(vmu_utcmdq_bits), 64'd0);
    checkOutput("rst_imm_bits", vmu_utimmq_bits, 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd0);
    checkOutput("rst_tvec_imm_rdy", 64'(tvec_imm_rdy), 64'd0);
    #1;
    reset = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tvec_imm_val = 1'b0;
    tick();

    $display("[TB] single TVEC command, no immediates");
    applyStimulus(1'b1, 19'h00123, 2'd0, 1'b0, '0, '0);
    exp_cmd_q.push_back(19'h00123);
    #1;
    checkOutput("t1_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd1);
    checkOutput("t1_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd0);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("t1_cmd_val", 64'(vmu_utcmdq_val), 64'd1);
    checkOutput("t1_cmd_bits", 64'(vmu_utcmdq_bits), 64'h00123);
    checkOutput("t1_imm_val", 64'(vmu_utimmq_val), 64'd0);

    $display("[TB] VT command with two immediates, TVEC waiting");
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00AB1, 2'd2);
    exp_cmd_q.push_back(19'h00AB1);
    #1;
    checkOutput("t2_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd1);
    checkOutput("t2_tvec_cmd_rdy0", 64'(tvec_cmd_rdy), 64'd0);
    tick();
    applyStimulus(1'b1, 19'h00456, 2'd0, 1'b0, '0, '0);
    exp_cmd_q.push_back(19'h00456);
    vt_imm_val  = 1'b1;
    vt_imm_bits = 64'hA;
    exp_imm_q.push_back(64'hA);
    #1;
    checkOutput("t2_lock1_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd0);
    checkOutput("t2_lock1_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd0);
    checkOutput("t2_lock1_vt_imm_rdy", 64'(vt_imm_rdy), 64'd1);
    checkOutput("t2_lock1_tvec_imm_rdy", 64'(tvec_imm_rdy), 64'd0);
    checkOutput("t2_lock1_busy", 64'(busy), 64'd1);
    tick();
    vt_imm_bits = 64'hB;
    exp_imm_q.push_back(64'hB);
    #1;
    checkOutput("t2_lock2_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd0);
    checkOutput("t2_lock2_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd0);
    checkOutput("t2_lock2_vt_imm_rdy", 64'(vt_imm_rdy), 64'd1);
    tick();
    vt_imm_val = 1'b0;
    #1;
    checkOutput("t2_unlock_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd1);
    checkOutput("t2_imm_b_val", 64'(vmu_utimmq_val), 64'd1);
    checkOutput("t2_imm_b_bits", vmu_utimmq_bits, 64'hB);
    tick();

    $display("[TB] both requesters continuously valid");
    applyStimulus(1'b1, 19'h00111, 2'd0, 1'b1, 19'h00222, 2'd0);
    #1;
    checkOutput("t2_cmd_456_bits", 64'(vmu_utcmdq_bits), 64'h00456);
    for (int i = 0; i < 8; i++) begin
      exp_cmd_q.push_back(vt_turn[i] ? 19'h00222 : 19'h00111);
      checkOutput($sformatf("t3_grant%0d_tvec_rdy", i), 64'(tvec_cmd_rdy), 64'(!vt_turn[i]));
      checkOutput($sformatf("t3_grant%0d_vt_rdy", i), 64'(vt_cmd_rdy), 64'(vt_turn[i]));
      tick();
      #1;
    end

    $display("[TB] downstream stall on the command queue");
    applyStimulus(1'b1, 19'h00333, 2'd0, 1'b0, '0, '0);
    exp_cmd_q.push_back(19'h00333);
    vmu_utcmdq_rdy = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("t4_stall%0d_bits", i), 64'(vmu_utcmdq_bits), 64'h00222);
      checkOutput($sformatf("t4_stall%0d_val", i), 64'(vmu_utcmdq_val), 64'd1);
      checkOutput($sformatf("t4_stall%0d_tvec_rdy", i), 64'(tvec_cmd_rdy), 64'd0);
      checkOutput($sformatf("t4_stall%0d_vt_rdy", i), 64'(vt_cmd_rdy), 64'd0);
      tick();
      #1;
    end
    vmu_utcmdq_rdy = 1'b1;
    #1;
    checkOutput("t4_reload_tvec_rdy", 64'(tvec_cmd_rdy), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("t4_reload_bits", 64'(vmu_utcmdq_bits), 64'h00333);
    checkOutput("t4_reload_val", 64'(vmu_utcmdq_val), 64'd1);

    $display("[TB] stray TVEC immediates while idle and during VT lock");
    tvec_imm_val  = 1'b1;
    tvec_imm_bits = 64'hDEAD;
    applyStimulus(1'b0, '0, '0, 1'b1, 19'h00777, 2'd1);
    exp_cmd_q.push_back(19'h00777);
    #1;
    checkOutput("t5_idle_tvec_imm_rdy", 64'(tvec_imm_rdy), 64'd0);
    checkOutput("t5_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("t5_lock_tvec_imm_rdy", 64'(tvec_imm_rdy), 64'd0);
    checkOutput("t5_lock_vt_imm_rdy", 64'(vt_imm_rdy), 64'd1);
    tick();
    #1;
    checkOutput("t5_no_imm_forwarded", 64'(vmu_utimmq_val), 64'd0);
    vt_imm_val  = 1'b1;
    vt_imm_bits = 64'hC;
    exp_imm_q.push_back(64'hC);
    #1;
    checkOutput("t5_vt_imm_rdy", 64'(vt_imm_rdy), 64'd1);
    tick();
    vt_imm_val   = 1'b0;
    tvec_imm_val = 1'b0;
    #1;
    checkOutput("t5_imm_c_val", 64'(vmu_utimmq_val), 64'd1);
    checkOutput("t5_imm_c_bits", vmu_utimmq_bits, 64'hC);

    $display("[TB] reset during an immediate lock");
    tick();
    applyStimulus(1'b1, 19'h00555, 2'd2, 1'b0, '0, '0);
    exp_cmd_q.push_back(19'h00555);
    #1;
    checkOutput("t6_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tvec_imm_val  = 1'b1;
    tvec_imm_bits = 64'h1;
    exp_imm_q.push_back(64'h1);
    #1;
    checkOutput("t6_tvec_imm_rdy_rem2", 64'(tvec_imm_rdy), 64'd1);
    tick();
    tvec_imm_bits = 64'h2;
    #1;
    checkOutput("t6_tvec_imm_rdy_rem1", 64'(tvec_imm_rdy), 64'd1);
    #4;
    applyStimulus(1'b1, 19'h00666, 2'd0, 1'b1, 19'h006A6, 2'd0);
    reset = 1'b0;
    #1;
    checkOutput("t6_rst_cmd_val", 64'(vmu_utcmdq_val), 64'd0);
    checkOutput("t6_rst_imm_val", 64'(vmu_utimmq_val), 64'd0);
    checkOutput("t6_rst_cmd_bits", 64'(vmu_utcmdq_bits), 64'd0);
    checkOutput("t6_rst_imm_bits", vmu_utimmq_bits, 64'd0);
    checkOutput("t6_rst_busy", 64'(busy), 64'd0);
    checkOutput("t6_rst_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd0);
    checkOutput("t6_rst_vt_cmd_rdy", 64'(vt_cmd_rdy), 64'd0);
    checkOutput("t6_rst_tvec_imm_rdy", 64'(tvec_imm_rdy), 64'd0);
    checkOutput("t6_rst_vt_imm_rdy", 64'(vt_imm_rdy), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    tvec_imm_val = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    applyStimulus(1'b1, 19'h00999, 2'd0, 1'b0, '0, '0);
    exp_cmd_q.push_back(19'h00999);
    #1;
    checkOutput("t6_post_tvec_cmd_rdy", 64'(tvec_cmd_rdy), 64'd1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    #1;
    checkOutput("t6_post_cmd_bits", 64'(vmu_utcmdq_bits), 64'h00999);
    checkOutput("t6_post_cmd_val", 64'(vmu_utcmdq_val), 64'd1);
    checkOutput("t6_post_imm_val", 64'(vmu_utimmq_val), 64'd0);
    tick();
    tick();
    checkOutput("cmd_queue_drained", 64'(exp_cmd_q.size()), 64'd0);
    checkOutput("imm_queue_drained", 64'(exp_imm_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
